avmm_lvds_req_framer: RTL
=========================

AVMM_LVDS_REQ_FRAMER -- requirements
Module: avmm_lvds_req_framer

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING_RD, default 4, giving the maximum number of read requests sent but not yet completed (range 1..255).
REQ-002 SHALL have ports:
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have Avalon-MM slave inputs:
- avs_address  in  19  word address (package address_t).
- avs_burstcount  in  11  burst length (package burstcnt_t).
- avs_byteenable  in  4  byte enables.
- avs_read  in  1  read command.
- avs_write  in  1  write command/beat.
- avs_writedata  in  32  write data.
REQ-004 SHALL have ports:
- avs_waitrequest  out  1  Avalon-MM stall.
- tx_data  out  32  link word.
- tx_valid  out  1  link word valid.
- tx_ready  in  1  link sink ready.
- rd_done  in  1  one-cycle pulse from the response path when a read completes.
- rd_outstanding  out  8  count of in-flight reads.
- busy  out  1  high whenever state is not IDLE.

Function
REQ-005 SHALL implement FSM states IDLE, HDR and WDATA.
REQ-006 SHALL format the header as the package req_hdr_t: tr at bit 31 (WRITE=0, READ=1), burst at bit 30, address at bits 29:11, burstcnt_byteena at bits 10:0.
REQ-007 SHALL set burst=BURST with burstcnt_byteena=burstcount when burstcount>1; otherwise burst=NOBURST with burstcnt_byteena={7'b0, byteenable}.
REQ-008 SHALL treat burstcount=0 as 1.
REQ-009 SHALL handle the IDLE state as follows:
- avs_waitrequest=1, tx_valid=0, tx_data=0.
- avs_write=1: latch the header, load beat counter=burstcount, go to HDR.
- avs_read=1 and rd_outstanding<MAX_OUTSTANDING_RD: latch the header, go to HDR.
- avs_read=1 and the limit is reached: stay in IDLE, waitrequest held at 1.
REQ-010 SHALL give avs_write priority when avs_read and avs_write are both high in IDLE; the read is ignored (protocol violation).
REQ-011 SHALL, in HDR, drive tx_valid=1 and tx_data=the latched header, holding both stable until tx_ready.
REQ-012 SHALL handle the HDR state on tx_ready=1 as follows:
- Read: avs_waitrequest=0 in that same cycle (command accepted), rd_outstanding increments, go to IDLE.
- Write: go to WDATA with avs_waitrequest still 1 (no beat consumed).
REQ-013 SHALL give a header latency of exactly one cycle: a command sampled in IDLE at cycle N has its header valid at cycle N+1.
REQ-014 SHALL, in WDATA, drive the following combinationally:
- tx_data=avs_writedata.
- tx_valid=avs_write.
- avs_waitrequest=~tx_ready.
REQ-015 SHALL count a beat when avs_write and tx_ready are both high, decrementing the beat counter; the beat at count 1 returns the FSM to IDLE.
REQ-016 SHALL let a new command be sampled in the IDLE cycle immediately following the last beat or the read acceptance.
REQ-017 SHALL forward neither per-beat byteenable during WDATA nor avs_address/avs_burstcount changes after latching.
REQ-018 SHALL update rd_outstanding as follows:
- +1 on read header acceptance.
- -1 on rd_done.
- Unchanged when both occur in the same cycle.
- rd_done at 0 is ignored (no wrap).
REQ-019 SHALL never raise rd_outstanding above MAX_OUTSTANDING_RD.
REQ-020 SHALL make busy=1 in HDR and WDATA and busy=0 in IDLE.

Reset
REQ-021 SHALL, on rst assertion and independent of clk, force the following regardless of state (including mid-burst):
- state=IDLE, beat counter=0, rd_outstanding=0.
- tx_valid=0, tx_data=0, avs_waitrequest=1, busy=0.
REQ-022 SHALL accept the first command on the first rising clk edge after rst deasserts.

Verification
REQ-023 SHALL be covered by these directed scenarios:
- Single write, addr 0x00123, byteenable 0xF, data 0xDEADBEEF, tx_ready=1 -> tx words 0x0009180F then 0xDEADBEEF; waitrequest low only in the data cycle.
- Burst read, addr 0x7FFFF, burstcount 1024 -> header 0xFFFFFC00; waitrequest low in one cycle; rd_outstanding 0->1.
- Burst write, addr 0x10, burstcount 4, tx_ready toggling 1/0 -> header 0x40008004, then exactly 4 data words in order; each beat is held under waitrequest while tx_ready=0.
- Five back-to-back single reads with MAX_OUTSTANDING_RD=4 and no rd_done -> 4 headers sent, 5th stalled; rd_done pulse releases it next cycle; simultaneous rd_done and acceptance -> count stays 4.
- rst asserted after beat 2 of a 4-beat write -> outputs immediately at reset values; a subsequent read produces a correct header.
- burstcount=0 write with byteenable 0x3 -> NOBURST header with bits 10:0 = 0x003 and one data beat.

Source files
------------

// File: rtl/avmm_lvds_req_framer.sv
// Avalon-MM slave to LVDS request framer: one header word per command, then
// write data beats forwarded under tx_ready back-pressure.
package avmm_lvds_pkg;
    typedef logic [18:0] address_t;
    typedef logic [10:0] burstcnt_t;
    typedef enum logic {WRITE = 1'b0, READ = 1'b1} tr_t;
    typedef enum logic {NOBURST = 1'b0, BURST = 1'b1} burst_t;
    typedef struct packed {
        tr_t       tr;
        burst_t    burst;
        address_t  address;
        burstcnt_t burstcnt_byteena;
    } req_hdr_t;
endpackage

module avmm_lvds_req_framer
    import avmm_lvds_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING_RD = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  address_t    avs_address,
    input  burstcnt_t   avs_burstcount,
    input  logic [3:0]  avs_byteenable,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic        avs_waitrequest,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic        rd_done,
    output logic [7:0]  rd_outstanding,
    output logic        busy
);

    localparam logic [7:0] MAX_RD = 8'(MAX_OUTSTANDING_RD);

    typedef enum logic [1:0] {IDLE, HDR, WDATA} state_t;

    state_t     state_q, state_d;
    req_hdr_t   hdr_q, hdr_d;
    burstcnt_t  beats_q, beats_d;
    logic [7:0] rd_out_q, rd_out_d;
    logic       rd_acc;
    logic       rd_dec;

    // Single beats carry byte enables in the length field; bursts carry the count.
    function automatic req_hdr_t build_hdr(input tr_t tr, input address_t addr,
                                           input burstcnt_t bc, input logic [3:0] be);
        req_hdr_t h;
        h.tr      = tr;
        h.address = addr;
        if (bc > 11'd1) begin
            h.burst            = BURST;
            h.burstcnt_byteena = bc;
        end else begin
            h.burst            = NOBURST;
            h.burstcnt_byteena = {7'b0, be};
        end
        return h;
    endfunction

    always_comb begin
        state_d         = state_q;
        hdr_d           = hdr_q;
        beats_d         = beats_q;
        rd_acc          = 1'b0;
        avs_waitrequest = 1'b1;
        tx_valid        = 1'b0;
        tx_data         = '0;
        case (state_q)
            IDLE: begin
                if (avs_write) begin
                    hdr_d   = build_hdr(WRITE, avs_address, avs_burstcount, avs_byteenable);
                    beats_d = (avs_burstcount == 11'd0) ? 11'd1 : avs_burstcount;
                    state_d = HDR;
                end else if (avs_read && (rd_out_q < MAX_RD)) begin
                    hdr_d   = build_hdr(READ, avs_address, avs_burstcount, avs_byteenable);
                    state_d = HDR;
                end
            end
            HDR: begin
                tx_valid = 1'b1;
                tx_data  = hdr_q;
                if (tx_ready) begin
                    if (hdr_q.tr == READ) begin
                        avs_waitrequest = 1'b0;
                        rd_acc          = 1'b1;
                        state_d         = IDLE;
                    end else begin
                        state_d = WDATA;
                    end
                end
            end
            WDATA: begin
                tx_data         = avs_writedata;
                tx_valid        = avs_write;
                avs_waitrequest = ~tx_ready;
                if (avs_write && tx_ready) begin
                    beats_d = beats_q - 11'd1;
                    if (beats_q == 11'd1) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A completion reported while nothing is in flight is dropped, so the count never wraps.
    always_comb begin
        rd_dec   = rd_done && (rd_out_q != 8'd0);
        rd_out_d = rd_out_q;
        case ({rd_acc, rd_dec})
            2'b10:   rd_out_d = rd_out_q + 8'd1;
            2'b01:   rd_out_d = rd_out_q - 8'd1;
            default: rd_out_d = rd_out_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            hdr_q    <= '0;
            beats_q  <= '0;
            rd_out_q <= '0;
        end else begin
            state_q  <= state_d;
            hdr_q    <= hdr_d;
            beats_q  <= beats_d;
            rd_out_q <= rd_out_d;
        end
    end

    assign rd_outstanding = rd_out_q;
    assign busy           = (state_q != IDLE);

endmodule
